// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dglitch_inv.sv
// Synchronizing deglitch filter with inverted, registered output.
// A level must hold FILT_CNT enabled clocks past the synchronizer to be accepted.
module gf180mcu_fd_sc_mcu9t5v0__dglitch_inv #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CNT    = 4
) (
   input  logic CLK,
   input  logic RN,
   input  logic EN,
   input  logic I,
   output logic ZN,
   output logic EDGE
);

   localparam int CNT_W = $clog2(FILT_CNT + 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_zn;
   logic                   r_edge;
   logic                   w_s;
   logic                   w_mis;
   logic                   w_done;

   assign w_s    = r_sync[SYNC_STAGES-1];
   // r_zn holds the inverted accepted level, so a mismatch is s == r_zn
   assign w_mis  = (w_s == r_zn);
   assign w_done = (r_cnt == CNT_W'(FILT_CNT - 1));

   always_ff @(posedge CLK) begin
      if (!RN) begin
         r_sync <= '0;
         r_cnt  <= '0;
         r_zn   <= 1'b1;
         r_edge <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], I};
         r_edge <= 1'b0;
         if (EN) begin
            if (!w_mis) begin
               r_cnt <= '0;
            end else if (w_done) begin
               r_zn   <= ~r_zn;
               r_cnt  <= '0;
               r_edge <= 1'b1;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign ZN   = r_zn;
   assign EDGE = r_edge;

endmodule
